// File: rtl/divider_arbiter_if.sv
// Client/divider bus bundle for divider_arbiter: level requests with per-client operands,
// one-hot acks with a shared result bus, and the start/valid handshake to the divider.
interface divider_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_dividend;
    logic [7*NREQ-1:0] req_divisor;
    logic [NREQ-1:0]   ack;
    logic [7:0]        res_quotient;
    logic [6:0]        res_remainder;
    logic              res_err;
    logic              busy;
    logic              div_start;
    logic [7:0]        div_dividendin;
    logic [6:0]        div_divisorin;
    logic [7:0]        div_quotient;
    logic [6:0]        div_remainder;
    logic              div_valid;

    modport slave (
        input  req, req_dividend, req_divisor, div_quotient, div_remainder, div_valid,
        output ack, res_quotient, res_remainder, res_err, busy,
               div_start, div_dividendin, div_divisorin
    );

    modport master (
        output req, req_dividend, req_divisor, div_quotient, div_remainder, div_valid,
        input  ack, res_quotient, res_remainder, res_err, busy,
               div_start, div_dividendin, div_divisorin
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one sequential 8b/7b divider among NREQ clients, with a
// stale-valid guard and timeout. Define DIV_ARB_ZERO_CHECK_EN to answer x/0 locally.
module divider_arbiter #(
    parameter int NREQ     = 4,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             reset,
    divider_arbiter_if.slave ifc
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_gnt_idx;
    logic [IW-1:0]   r_rr_ptr;
    logic            r_just_done;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_ack;
    logic            r_busy;
    logic            r_div_start;
    logic            r_res_err;
    logic [7:0]      r_dvd;
    logic [6:0]      r_dvs;
    logic [7:0]      r_res_q;
    logic [6:0]      r_res_r;

    logic [NREQ-1:0] w_elig;
    logic [IW:0]     w_idx;
    logic            w_any;
    logic [IW-1:0]   w_gnt_idx;
    logic [7:0]      w_sel_dvd;
    logic [6:0]      w_sel_dvs;

    // The client acked last cycle is still dropping its req, so it sits out one IDLE cycle.
    always_comb begin
        w_elig = ifc.req;
        if (r_just_done) w_elig[r_rr_ptr] = 1'b0;
    end

    // Scan from farthest to nearest after rr_ptr so the nearest eligible client wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = (IW+1)'(r_rr_ptr) + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
            if (w_elig[w_idx[IW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IW'(i)) begin
                w_sel_dvd = ifc.req_dividend[8*i +: 8];
                w_sel_dvs = ifc.req_divisor[7*i +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= IW'(NREQ - 1);
            r_just_done <= 1'b0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_div_start <= 1'b0;
            r_res_err   <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_res_q     <= '0;
            r_res_r     <= '0;
        end else begin
            r_ack       <= '0;
            r_div_start <= 1'b0;
            r_just_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_dvd     <= w_sel_dvd;
                        r_dvs     <= w_sel_dvs;
                        r_busy    <= 1'b1;
`ifdef DIV_ARB_ZERO_CHECK_EN
                        if (w_sel_dvs == '0) begin
                            r_state   <= DONE;
                            r_ack     <= NREQ'(1) << w_gnt_idx;
                            r_res_q   <= 8'hFF;
                            r_res_r   <= w_sel_dvd[6:0];
                            r_res_err <= 1'b1;
                        end else begin
                            r_state     <= START;
                            r_div_start <= 1'b1;
                        end
`else
                        r_state     <= START;
                        r_div_start <= 1'b1;
`endif
                    end
                end
                START: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Early valids may be left over from the divider's previous operation.
                    if (ifc.div_valid && r_cnt >= CW'(MIN_WAIT)) begin
                        r_res_q   <= ifc.div_quotient;
                        r_res_r   <= ifc.div_remainder;
                        r_res_err <= 1'b0;
                        r_ack     <= NREQ'(1) << r_gnt_idx;
                        r_state   <= DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_res_q   <= '0;
                        r_res_r   <= '0;
                        r_res_err <= 1'b1;
                        r_ack     <= NREQ'(1) << r_gnt_idx;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_rr_ptr    <= r_gnt_idx;
                    r_just_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ifc.ack            = r_ack;
    assign ifc.res_quotient   = r_res_q;
    assign ifc.res_remainder  = r_res_r;
    assign ifc.res_err        = r_res_err;
    assign ifc.busy           = r_busy;
    assign ifc.div_start      = r_div_start;
    assign ifc.div_dividendin = r_dvd;
    assign ifc.div_divisorin  = r_dvs;
endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: behavioural divider stub plus directed and randomized
// round-robin traffic checked against arithmetic expectations.
module tb_divider_arbiter;
    localparam int NREQ     = 4;
    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    divider_arbiter_if #(.NREQ(NREQ)) ifc ();

    divider_arbiter #(.NREQ(NREQ), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    // Divider stub: mode 0 pulses valid lat+1 cycles after start (lat 0 = random 2..6),
    // mode 1 holds valid high, mode 2 never asserts valid.
    int         mode = 0;
    int         lat  = 2;
    logic [2:0] dcnt = '0;
    logic [7:0] m_dvd = '0;
    logic [6:0] m_dvs = '0;

    always @(posedge clk) begin
        if (ifc.div_start) begin
            m_dvd <= ifc.div_dividendin;
            m_dvs <= ifc.div_divisorin;
            dcnt  <= (lat == 0) ? 3'($urandom_range(2, 6)) : 3'(lat);
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1'b1;
        end
        ifc.div_valid <= (mode == 1) || (mode == 0 && dcnt == 3'd1 && !ifc.div_start);
    end

    always_comb begin
        ifc.div_quotient  = 8'hFF;
        ifc.div_remainder = m_dvd[6:0];
        if (m_dvs != 0) begin
            ifc.div_quotient  = m_dvd / {1'b0, m_dvs};
            ifc.div_remainder = 7'(m_dvd % {1'b0, m_dvs});
        end
    end

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] dvd [NREQ];
    logic [6:0] dvs [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.req = '0;
        ifc.req_dividend = '0;
        ifc.req_divisor = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [6:0] b);
        dvd[i] = a;
        dvs[i] = b;
        ifc.req_dividend[8*i +: 8] = a;
        ifc.req_divisor[7*i +: 7]  = b;
        ifc.req[i] = 1'b1;
    endtask

    // Returns cycles elapsed until an ack is visible and the div_starts seen meanwhile.
    task automatic wait_ack(input string tag, output int cyc, output int starts);
        cyc = 0;
        starts = 0;
        while (ifc.ack == '0 && cyc < 100) begin
            if (ifc.div_start) starts++;
            tick();
            cyc++;
        end
        if (ifc.ack == '0) chk({tag, "_ack_timeout"}, 32'(ifc.ack != '0), 1);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int from);
        for (int k = 1; k <= NREQ; k++)
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, st, n, ops, exp_idx, last;
        int hold [NREQ];

        // Reset state
        do_reset();
        chk("rst_busy", ifc.busy, 0);
        chk("rst_ack", ifc.ack, 0);
        chk("rst_start", ifc.div_start, 0);
        chk("rst_err", ifc.res_err, 0);
        chk("rst_res", {ifc.res_quotient, ifc.res_remainder}, 0);
        chk("rst_opnd", {ifc.div_dividendin, ifc.div_divisorin}, 0);

        // Single request 200/7
        mode = 0; lat = 2;
        set_req(0, 8'd200, 7'd7);
        tick();
        chk("single_start", ifc.div_start, 1);
        chk("single_busy", ifc.busy, 1);
        chk("single_opnd", {ifc.div_dividendin, ifc.div_divisorin}, {8'd200, 7'd7});
        wait_ack("single", cyc, st);
        chk("single_lat", cyc, 4);
        chk("single_ack", ifc.ack, 4'b0001);
        chk("single_q", ifc.res_quotient, 28);
        chk("single_r", ifc.res_remainder, 4);
        chk("single_err", ifc.res_err, 0);
        ifc.req[0] = 1'b0;
        tick();
        chk("single_ack_pulse", ifc.ack, 0);
        chk("single_idle", ifc.busy, 0);

        // Fairness with all four held
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 8'($urandom_range(0, 255)), 7'($urandom_range(1, 127)));
        for (int k = 0; k < 5; k++) begin
            wait_ack("fair", cyc, st);
            chk("fair_order", ifc.ack, 32'(1) << (k % NREQ));
            chk("fair_q", ifc.res_quotient, int'(dvd[k % NREQ]) / int'(dvs[k % NREQ]));
            chk("fair_r", ifc.res_remainder, int'(dvd[k % NREQ]) % int'(dvs[k % NREQ]));
            chk("fair_starts", st, 1);
            tick();
        end

        // Sole requester re-requesting: regrant skips one IDLE cycle
        do_reset();
        set_req(2, 8'd50, 7'd5);
        wait_ack("sole", cyc, st);
        chk("sole_ack", ifc.ack, 4'b0100);
        chk("sole_q", {ifc.res_quotient, ifc.res_remainder}, {8'd10, 7'd0});
        tick();
        n = 1;
        while (!ifc.div_start && n < 10) begin
            tick();
            n++;
        end
        chk("sole_regrant", n, 3);

        // Stale valid: valid tied high, accepted only at WAIT count MIN_WAIT
        do_reset();
        mode = 1;
        set_req(1, 8'd100, 7'd9);
        tick();
        chk("stale_start", ifc.div_start, 1);
        wait_ack("stale", cyc, st);
        chk("stale_lat", cyc, MIN_WAIT + 2);
        chk("stale_q", {ifc.res_quotient, ifc.res_remainder}, {8'd11, 7'd1});
        chk("stale_err", ifc.res_err, 0);
        ifc.req[1] = 1'b0;
        tick();

        // Timeout: valid never arrives
        mode = 2;
        set_req(3, 8'd77, 7'd3);
        tick();
        chk("tmo_start", ifc.div_start, 1);
        wait_ack("tmo", cyc, st);
        chk("tmo_lat", cyc, TIMEOUT + 1);
        chk("tmo_ack", ifc.ack, 4'b1000);
        chk("tmo_q", {ifc.res_quotient, ifc.res_remainder}, 0);
        chk("tmo_err", ifc.res_err, 1);

        // Reset in the middle of WAIT
        do_reset();
        mode = 0; lat = 2;
        set_req(1, 8'd90, 7'd8);
        wait_ack("pre", cyc, st);
        chk("pre_q", {ifc.res_quotient, ifc.res_remainder}, {8'd11, 7'd2});
        ifc.req[1] = 1'b0;
        tick();
        mode = 2;
        set_req(2, 8'd60, 7'd6);
        tick();
        chk("mid_start", ifc.div_start, 1);
        repeat (6) tick();
        reset = 1'b1;
        set_req(0, 8'd33, 7'd4);
        set_req(1, 8'd21, 7'd5);
        set_req(3, 8'd99, 7'd9);
        tick();
        chk("mid_busy", ifc.busy, 0);
        chk("mid_noack", ifc.ack, 0);
        chk("mid_nostart", ifc.div_start, 0);
        reset = 1'b0;
        mode = 0;
        tick();
        chk("mid_regrant", ifc.div_start, 1);
        chk("mid_opnd", {ifc.div_dividendin, ifc.div_divisorin}, {8'd33, 7'd4});
        wait_ack("mid", cyc, st);
        chk("mid_ack", ifc.ack, 4'b0001);
        chk("mid_q", {ifc.res_quotient, ifc.res_remainder}, {8'd8, 7'd1});

        // Zero divisor
        do_reset();
        mode = 0; lat = 2;
        set_req(1, 8'd100, 7'd0);
        tick();
`ifdef DIV_ARB_ZERO_CHECK_EN
        chk("zero_nostart", ifc.div_start, 0);
        chk("zero_ack", ifc.ack, 4'b0010);
        chk("zero_q", ifc.res_quotient, 8'hFF);
        chk("zero_r", ifc.res_remainder, 100);
        chk("zero_err", ifc.res_err, 1);
`else
        chk("zero_start", ifc.div_start, 1);
        chk("zero_dvs", ifc.div_divisorin, 0);
        wait_ack("zero", cyc, st);
        chk("zero_ack", ifc.ack, 4'b0010);
        chk("zero_q", {ifc.res_quotient, ifc.res_remainder}, {8'hFF, 7'd100});
        chk("zero_err", ifc.res_err, 0);
`endif

        // Randomized traffic against a round-robin reference
        do_reset();
        mode = 0; lat = 0;
        ops = 0; exp_idx = -1; last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) hold[i] = 0;
        for (int c = 0; c < 3000 && ops < 40; c++) begin
            if (ifc.div_start) begin
                exp_idx = rr_pick(ifc.req, last);
                if (exp_idx >= 0)
                    chk("rnd_opnd", {ifc.div_dividendin, ifc.div_divisorin},
                        {dvd[exp_idx], dvs[exp_idx]});
                else
                    chk("rnd_spurious_start", ifc.div_start, 0);
            end
            if (ifc.ack != '0) begin
                if (exp_idx < 0) begin
                    chk("rnd_spurious_ack", ifc.ack, 0);
                end else begin
                    chk("rnd_ack", ifc.ack, 32'(1) << exp_idx);
                    chk("rnd_q", ifc.res_quotient, int'(dvd[exp_idx]) / int'(dvs[exp_idx]));
                    chk("rnd_r", ifc.res_remainder, int'(dvd[exp_idx]) % int'(dvs[exp_idx]));
                    chk("rnd_err", ifc.res_err, 0);
                    last = exp_idx;
                    ifc.req[exp_idx] = 1'b0;
                    hold[exp_idx] = $urandom_range(2, 4);
                    exp_idx = -1;
                    ops++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!ifc.req[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else if ($urandom_range(0, 3) == 0)
                        set_req(i, 8'($urandom_range(0, 255)), 7'($urandom_range(1, 127)));
                end
            end
            tick();
        end
        chk("rnd_ops", ops, 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
